axi4lite_slave_regs: RTL and testbench

AXI4-Lite responder (slave) exposing a bank of 32-bit read/write registers; it is the DUT-side endpoint that the testbench driver and monitor talk to. It accepts write address/data in either order, commits byte-strobed writes, returns write responses, and serves single-beat reads with registered data. Write and read channels run independently, each with its own FSM.

---
 rtl/axi4lite_slave_regs_pkg.sv | 24 ++
 rtl/axi4lite_regfile.sv | 39 +++
 rtl/axi4lite_slave_regs.sv | 197 +++++++++++++++++++
 tb/tb_axi4lite_slave_regs.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_slave_regs_pkg.sv
// Shared types for the AXI4-Lite register responder: response codes, channel FSM states
// and the default register count.
package axi4lite_slave_regs_pkg;

    localparam int unsigned NUM_REGS_DEF = 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/axi4lite_regfile.sv
// Word register bank: byte-strobed synchronous write port, combinational read port,
// synchronous active-high clear.
module axi4lite_regfile
    import axi4lite_slave_regs_pkg::*;
#(
    parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int unsigned STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_widx,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [STRB_W-1:0]     i_wstrb,
    input  logic [IDX_W-1:0]      i_ridx,
    output logic [DATA_WIDTH-1:0] o_rdata_c
);

    logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata_c = r_mem[i_ridx];

endmodule

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite responder over a bank of 32-bit registers, independent write and read FSMs.
// Build option AXI4LITE_SLVERR_EN: undecodable addresses answer SLVERR instead of OKAY.
module axi4lite_slave_regs
    import axi4lite_slave_regs_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = NUM_REGS_DEF
) (
    input  logic                    i_aclk,
    input  logic                    i_areset,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rvalid,
    input  logic                    i_rready
);

    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
`ifdef AXI4LITE_SLVERR_EN
    localparam axi_resp_t BAD_RESP = RESP_SLVERR;
`else
    localparam axi_resp_t BAD_RESP = RESP_OKAY;
`endif

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a < ADDR_LIMIT) && (a[1:0] == 2'b00);
    endfunction

    // Write channel state
    w_state_t              r_wstate,  w_wstate_nxt;
    logic                  r_aw_got,  w_aw_got_nxt;
    logic                  r_w_got,   w_w_got_nxt;
    logic [ADDR_WIDTH-1:0] r_awaddr,  w_awaddr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata,   w_wdata_nxt;
    logic [STRB_W-1:0]     r_wstrb,   w_wstrb_nxt;
    logic                  r_bvalid,  w_bvalid_nxt;
    axi_resp_t             r_bresp,   w_bresp_nxt;

    // Read channel state
    r_state_t              r_rstate,  w_rstate_nxt;
    logic                  r_rvalid,  w_rvalid_nxt;
    logic [DATA_WIDTH-1:0] r_rdata,   w_rdata_nxt;
    axi_resp_t             r_rresp,   w_rresp_nxt;

    logic                  w_aw_hs, w_w_hs, w_ar_hs;
    logic                  w_have_aw, w_have_w, w_commit, w_waddr_ok;
    logic [ADDR_WIDTH-1:0] w_eff_addr;
    logic [DATA_WIDTH-1:0] w_eff_data;
    logic [STRB_W-1:0]     w_eff_strb;
    logic [DATA_WIDTH-1:0] w_rf_rdata;

    assign o_awready = (r_wstate == W_IDLE) && !r_aw_got && !i_areset;
    assign o_wready  = (r_wstate == W_IDLE) && !r_w_got  && !i_areset;
    assign o_arready = (r_rstate == R_IDLE) && !i_areset;

    assign w_aw_hs = i_awvalid && o_awready;
    assign w_w_hs  = i_wvalid  && o_wready;
    assign w_ar_hs = i_arvalid && o_arready;

    // A beat arriving this cycle takes precedence over the held copy of its channel.
    assign w_eff_addr = w_aw_hs ? i_awaddr : r_awaddr;
    assign w_eff_data = w_w_hs  ? i_wdata  : r_wdata;
    assign w_eff_strb = w_w_hs  ? i_wstrb  : r_wstrb;
    assign w_have_aw  = r_aw_got || w_aw_hs;
    assign w_have_w   = r_w_got  || w_w_hs;
    assign w_commit   = (r_wstate == W_IDLE) && w_have_aw && w_have_w;
    assign w_waddr_ok = addr_ok(w_eff_addr);

    axi4lite_regfile #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regfile (
        .i_clk     (i_aclk),
        .i_rst     (i_areset),
        .i_we      (w_commit && w_waddr_ok),
        .i_widx    (w_eff_addr[IDX_W+1:2]),
        .i_wdata   (w_eff_data),
        .i_wstrb   (w_eff_strb),
        .i_ridx    (i_araddr[IDX_W+1:2]),
        .o_rdata_c (w_rf_rdata)
    );

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_wstate <= W_IDLE;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_aw_got <= w_aw_got_nxt;
            r_w_got  <= w_w_got_nxt;
            r_awaddr <= w_awaddr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_wstrb  <= w_wstrb_nxt;
            r_bvalid <= w_bvalid_nxt;
            r_bresp  <= w_bresp_nxt;
            r_rstate <= w_rstate_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_rdata  <= w_rdata_nxt;
            r_rresp  <= w_rresp_nxt;
        end
    end

    // Write FSM: collect AW and W in any order, commit on the cycle the pair completes.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_aw_got_nxt = r_aw_got;
        w_w_got_nxt  = r_w_got;
        w_awaddr_nxt = r_awaddr;
        w_wdata_nxt  = r_wdata;
        w_wstrb_nxt  = r_wstrb;
        w_bvalid_nxt = r_bvalid;
        w_bresp_nxt  = r_bresp;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs) w_awaddr_nxt = i_awaddr;
                if (w_w_hs) begin
                    w_wdata_nxt = i_wdata;
                    w_wstrb_nxt = i_wstrb;
                end
                if (w_commit) begin
                    w_wstate_nxt = W_RESP;
                    w_bvalid_nxt = 1'b1;
                    w_bresp_nxt  = w_waddr_ok ? RESP_OKAY : BAD_RESP;
                    w_aw_got_nxt = 1'b0;
                    w_w_got_nxt  = 1'b0;
                end else begin
                    w_aw_got_nxt = w_have_aw;
                    w_w_got_nxt  = w_have_w;
                end
            end
            W_RESP: begin
                if (i_bready) begin
                    w_wstate_nxt = W_IDLE;
                    w_bvalid_nxt = 1'b0;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Read FSM: sample the bank on the AR handshake, hold the beat until RREADY.
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rvalid_nxt = r_rvalid;
        w_rdata_nxt  = r_rdata;
        w_rresp_nxt  = r_rresp;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_rstate_nxt = R_DATA;
                    w_rvalid_nxt = 1'b1;
                    w_rdata_nxt  = addr_ok(i_araddr) ? w_rf_rdata : '0;
                    w_rresp_nxt  = addr_ok(i_araddr) ? RESP_OKAY : BAD_RESP;
                end
            end
            R_DATA: begin
                if (i_rready) begin
                    w_rstate_nxt = R_IDLE;
                    w_rvalid_nxt = 1'b0;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    assign o_bvalid = r_bvalid;
    assign o_bresp  = r_bresp;
    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;
    assign o_rresp  = r_rresp;

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Scoreboard bench for axi4lite_slave_regs: driver tasks queue expected B/R responses from a
// word-array model, a negedge monitor pops and compares on every B/R handshake.
module tb_axi4lite_slave_regs;

    localparam int NREG = 8;
`ifdef AXI4LITE_SLVERR_EN
    localparam logic [1:0] BAD = 2'b10;
`else
    localparam logic [1:0] BAD = 2'b00;
`endif

    logic        clk = 1'b0;
    logic        i_areset;
    logic [31:0] i_awaddr, i_wdata, i_araddr;
    logic        i_awvalid, i_wvalid, i_bready, i_arvalid, i_rready;
    logic [3:0]  i_wstrb;
    logic        o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
    logic [1:0]  o_bresp, o_rresp;
    logic [31:0] o_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [NREG];
    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];

    always #5 clk = ~clk;

    axi4lite_slave_regs dut (
        .i_aclk(clk), .i_areset(i_areset),
        .i_awaddr(i_awaddr), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_araddr(i_araddr), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rvalid(o_rvalid), .i_rready(i_rready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic bit addr_valid(input logic [31:0] a);
        return (a < 32'(NREG * 4)) && (a % 4 == 0);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp);
        resp = BAD;
        if (addr_valid(a)) begin
            resp = 2'b00;
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[a / 4][b*8 +: 8] = d[b*8 +: 8];
            end
        end
    endtask

    function automatic logic [33:0] model_read(input logic [31:0] a);
        if (addr_valid(a)) return {2'b00, model[a / 4]};
        return {BAD, 32'h0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) model[i] = 32'h0;
    endtask

    // Monitor: every B or R handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!i_areset) begin
            if (o_bvalid && i_bready) begin
                if (exp_b.size() == 0) chk("b_unexpected", 64'(exp_b.size()), 64'd1);
                else chk("bresp", 64'(o_bresp), 64'(exp_b.pop_front()));
            end
            if (o_rvalid && i_rready) begin
                if (exp_r.size() == 0) chk("r_unexpected", 64'(exp_r.size()), 64'd1);
                else chk("rresp_rdata", 64'({o_rresp, o_rdata}), 64'(exp_r.pop_front()));
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly);
        logic [1:0] resp;
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        int t = 0;
        model_write(a, d, s, resp);
        exp_b.push_back(resp);
        i_awaddr = a;
        i_wdata  = d;
        i_wstrb  = s;
        while (!(aw_done && w_done) && t < 100) begin
            i_awvalid = !aw_done && (t >= aw_dly);
            i_wvalid  = !w_done  && (t >= w_dly);
            @(negedge clk);
            chk("bvalid_early", 64'(o_bvalid), 64'd0);
            if (i_awvalid && o_awready) aw_done = 1'b1;
            if (i_wvalid && o_wready)   w_done  = 1'b1;
            @(posedge clk); #1;
            t++;
        end
        i_awvalid = 1'b0;
        i_wvalid  = 1'b0;
        chk("write_handshakes", 64'({aw_done, w_done}), 64'd3);
        chk("b_latency", 64'(o_bvalid), 64'd1);
    endtask

    task automatic do_read(input logic [31:0] a);
        bit got = 1'b0;
        int t = 0;
        exp_r.push_back(model_read(a));
        i_araddr  = a;
        i_arvalid = 1'b1;
        while (!got && t < 100) begin
            @(negedge clk);
            got = o_arready;
            @(posedge clk); #1;
            t++;
        end
        i_arvalid = 1'b0;
        chk("ar_handshake", 64'(got), 64'd1);
        chk("r_latency", 64'(o_rvalid), 64'd1);
    endtask

    task automatic wait_b(input int hold);
        bit seen = 1'b0;
        int t = 0;
        repeat (hold) begin @(posedge clk); #1; end
        i_bready = 1'b1;
        while (!seen && t < 50) begin
            @(negedge clk);
            seen = o_bvalid;
            @(posedge clk); #1;
            t++;
        end
        i_bready = 1'b0;
        chk("b_handshake", 64'(seen), 64'd1);
    endtask

    task automatic wait_r(input int hold);
        bit seen = 1'b0;
        int t = 0;
        repeat (hold) begin @(posedge clk); #1; end
        i_rready = 1'b1;
        while (!seen && t < 50) begin
            @(negedge clk);
            seen = o_rvalid;
            @(posedge clk); #1;
            t++;
        end
        i_rready = 1'b0;
        chk("r_handshake", 64'(seen), 64'd1);
    endtask

    task automatic read_all();
        for (int i = 0; i < NREG; i++) begin
            do_read(32'(i * 4));
            wait_r(0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] a;
        i_areset = 1'b1;
        i_awaddr = '0; i_wdata = '0; i_araddr = '0; i_wstrb = '0;
        i_awvalid = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0; i_arvalid = 1'b0; i_rready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_readies", 64'({o_awready, o_wready, o_arready}), 64'd0);
        chk("rst_valids", 64'({o_bvalid, o_rvalid}), 64'd0);
        chk("rst_resp_data", 64'({o_bresp, o_rresp, o_rdata}), 64'd0);
        @(posedge clk); #1;
        i_areset = 1'b0;
        @(negedge clk);
        chk("idle_readies", 64'({o_awready, o_wready, o_arready}), 64'd7);
        @(posedge clk); #1;

        // Same-cycle AW/W, then W three cycles ahead of AW.
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0); wait_b(0);
        do_read(32'h04); wait_r(0);
        do_write(32'h08, 32'h11223344, 4'hF, 3, 0); wait_b(0);
        do_read(32'h08); wait_r(0);
        do_write(32'h18, 32'h55667788, 4'hF, 0, 2); wait_b(0);

        // Single byte lane merge and an all-lanes-off write.
        do_write(32'h0C, 32'hFFFFFFFF, 4'hF, 0, 0); wait_b(0);
        do_write(32'h0C, 32'h00AB0000, 4'b0100, 1, 0); wait_b(0);
        do_read(32'h0C); wait_r(0);
        do_write(32'h04, 32'h0BADF00D, 4'h0, 0, 0); wait_b(0);

        // Out-of-range and misaligned accesses.
        do_write(32'h20, 32'h12345678, 4'hF, 0, 0); wait_b(0);
        do_write(32'h06, 32'h87654321, 4'hF, 0, 1); wait_b(0);
        do_read(32'h20); wait_r(0);
        do_read(32'h09); wait_r(0);
        read_all();

        // Both response channels stalled for ten cycles.
        do_write(32'h10, 32'hA5A5A5A5, 4'hF, 0, 0);
        do_read(32'h08);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valids", 64'({o_bvalid, o_rvalid}), 64'd3);
            chk("stall_bresp", 64'(o_bresp), 64'(exp_b[0]));
            chk("stall_rdata", 64'({o_rresp, o_rdata}), 64'(exp_r[0]));
            chk("stall_readies", 64'({o_awready, o_wready, o_arready}), 64'd0);
            @(posedge clk); #1;
        end
        wait_b(0); wait_r(0);

        // Write commit and read of the same register in one cycle: read sees the old value.
        exp_r.push_back(model_read(32'h10));
        model_write(32'h10, 32'h5A5A0F0F, 4'hF, resp);
        exp_b.push_back(resp);
        i_awaddr = 32'h10; i_wdata = 32'h5A5A0F0F; i_wstrb = 4'hF; i_araddr = 32'h10;
        i_awvalid = 1'b1; i_wvalid = 1'b1; i_arvalid = 1'b1;
        @(negedge clk);
        chk("same_cycle_readies", 64'({o_awready, o_wready, o_arready}), 64'd7);
        @(posedge clk); #1;
        i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
        chk("same_cycle_valids", 64'({o_bvalid, o_rvalid}), 64'd3);
        wait_b(0); wait_r(0);
        do_read(32'h10); wait_r(0);

        // Randomized mix against the model.
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                7:       a = 32'h20;
                8:       a = 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
                9:       a = $urandom;
                default: a = 32'($urandom_range(0, 7) * 4);
            endcase
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
                wait_b($urandom_range(0, 2));
            end else begin
                do_read(a);
                wait_r($urandom_range(0, 2));
            end
        end
        read_all();

        // Reset while a write response is pending: response dropped, bank cleared.
        do_write(32'h14, 32'hCAFEF00D, 4'hF, 0, 0);
        i_areset = 1'b1;
        exp_b.delete();
        exp_r.delete();
        model_reset();
        @(posedge clk); #1;
        chk("rst_drops_bvalid", 64'(o_bvalid), 64'd0);
        @(posedge clk); #1;
        i_areset = 1'b0;
        i_bready = 1'b1;
        i_rready = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        i_bready = 1'b0;
        i_rready = 1'b0;
        read_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
